// File: rtl/ofm_bank_buf_if.sv
// rtl/ofm_bank_buf_if.sv - write/read request and response bundle for ofm_bank_buf
interface ofm_bank_buf_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 11,
    parameter int NUM_BANKS  = 2
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);

    logic                  wr_valid;
    logic                  wr_ready;
    logic [BANK_BITS-1:0]  wr_bank;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_acc;
    logic                  rd_valid_in;
    logic                  rd_ready;
    logic [BANK_BITS-1:0]  rd_bank;
    logic [ADDR_BITS-1:0]  rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;

    modport master (
        output wr_valid, wr_bank, wr_addr, wr_data, wr_acc,
        output rd_valid_in, rd_bank, rd_addr,
        input  wr_ready, rd_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  wr_valid, wr_bank, wr_addr, wr_data, wr_acc,
        input  rd_valid_in, rd_bank, rd_addr,
        output wr_ready, rd_ready, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/ofm_bank_buf.sv
// rtl/ofm_bank_buf.sv - banked OFM buffer, single-port banks, optional saturating accumulate (OFM_ACC_EN)
module ofm_bank_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 11,
    parameter int NUM_BANKS  = 2
) (
    input  logic         clk,
    input  logic         rst,
    ofm_bank_buf_if.slave bus
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int MEM_AW    = BANK_BITS + ADDR_BITS;
    localparam int DEPTH     = 1 << MEM_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  occ_valid;
    logic [BANK_BITS-1:0]  occ_bank;
    logic                  rd_fire;

`ifdef OFM_ACC_EN
    typedef enum logic [1:0] {IDLE, ACC_RD, ACC_WR} state_t;

    state_t                state_q, state_d;
    logic                  acc_start;
    logic [BANK_BITS-1:0]  acc_bank;
    logic [ADDR_BITS-1:0]  acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [DATA_WIDTH-1:0] acc_old;
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH-1:0] acc_sum;

    // One guard bit: overflow shows up as the top two sum bits disagreeing.
    always_comb begin
        sum_ext = {acc_old[DATA_WIDTH-1], acc_old} + {acc_data[DATA_WIDTH-1], acc_data};
        acc_sum = sum_ext[DATA_WIDTH-1:0];
        if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
            acc_sum = sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_start    = 1'b0;
        bus.busy     = 1'b0;
        bus.wr_ready = 1'b1;
        mem_we       = 1'b0;
        mem_waddr    = {bus.wr_bank, bus.wr_addr};
        mem_wdata    = bus.wr_data;
        occ_valid    = bus.wr_valid;
        occ_bank     = bus.wr_bank;
        case (state_q)
            IDLE: begin
                if (bus.wr_valid) begin
                    if (bus.wr_acc) begin
                        acc_start = 1'b1;
                        state_d   = ACC_RD;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            ACC_RD: begin
                bus.busy     = 1'b1;
                bus.wr_ready = 1'b0;
                occ_valid    = 1'b1;
                occ_bank     = acc_bank;
                state_d      = ACC_WR;
            end
            ACC_WR: begin
                bus.busy     = 1'b1;
                bus.wr_ready = 1'b0;
                occ_valid    = 1'b1;
                occ_bank     = acc_bank;
                mem_we       = 1'b1;
                mem_waddr    = {acc_bank, acc_addr};
                mem_wdata    = acc_sum;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_bank <= '0;
            acc_addr <= '0;
            acc_data <= '0;
            acc_old  <= '0;
        end else begin
            state_q <= state_d;
            if (acc_start) begin
                acc_bank <= bus.wr_bank;
                acc_addr <= bus.wr_addr;
                acc_data <= bus.wr_data;
            end
            if (state_q == ACC_RD) begin
                acc_old <= mem[{acc_bank, acc_addr}];
            end
        end
    end
`else
    logic unused_wr_acc;

    assign unused_wr_acc = bus.wr_acc;

    always_comb begin
        bus.busy     = 1'b0;
        bus.wr_ready = 1'b1;
        mem_we       = bus.wr_valid;
        mem_waddr    = {bus.wr_bank, bus.wr_addr};
        mem_wdata    = bus.wr_data;
        occ_valid    = bus.wr_valid;
        occ_bank     = bus.wr_bank;
    end
`endif

    // The write path owns its bank for the cycle; a colliding read is held off.
    assign bus.rd_ready = rst | ~(occ_valid & (occ_bank == bus.rd_bank));
    assign rd_fire      = bus.rd_valid_in & bus.rd_ready;

    // Gating on rst keeps an aborted accumulate from landing in the array.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= rd_fire;
            if (rd_fire) begin
                bus.rd_data <= mem[{bus.rd_bank, bus.rd_addr}];
            end
        end
    end
endmodule

// File: tb/tb_ofm_bank_buf.sv
// tb/tb_ofm_bank_buf.sv - self-checking bench for ofm_bank_buf (covers OFM_ACC_EN on and off)
module tb_ofm_bank_buf;
    localparam int DW = 8;
    localparam int AB = 11;
    localparam int NB = 2;
`ifdef OFM_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ofm_bank_buf_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_BANKS(NB)) bus ();
    ofm_bank_buf #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_BANKS(NB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s[7:0];
    endfunction

    // Reference model: word store keyed by bank*depth+addr, plus an accumulate countdown.
    logic [7:0] mdl [int];
    int         acc_left = 0;
    int         acc_bank = 0;
    int         acc_key  = 0;
    logic [7:0] acc_d    = '0;
    bit         pend     = 1'b0;
    logic [7:0] pend_data = '0;

    always @(negedge clk) begin : model
        bit exp_busy;
        bit occ;
        int ob;
        bit e_rdy;
        if (rst) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_wr_ready", bus.wr_ready, 1);
            chk("rst_rd_ready", bus.rd_ready, 1);
            chk("rst_rd_valid", bus.rd_valid, 0);
            chk("rst_rd_data", bus.rd_data, 0);
            acc_left = 0;
            pend     = 1'b0;
        end else begin
            exp_busy = (acc_left > 0);
            occ      = exp_busy || bus.wr_valid;
            ob       = exp_busy ? acc_bank : int'(bus.wr_bank);
            e_rdy    = !(occ && ob == int'(bus.rd_bank));
            chk("busy", bus.busy, exp_busy);
            chk("wr_ready", bus.wr_ready, !exp_busy);
            chk("rd_ready", bus.rd_ready, e_rdy);
            chk("rd_valid", bus.rd_valid, pend);
            if (pend) chk("rd_data", bus.rd_data, pend_data);
            pend = bus.rd_valid_in && e_rdy;
            if (pend) pend_data = mdl[int'(bus.rd_bank) * (1 << AB) + int'(bus.rd_addr)];
            if (acc_left > 0) begin
                acc_left--;
                if (acc_left == 0) mdl[acc_key] = sat_add(mdl[acc_key], acc_d);
            end else if (bus.wr_valid) begin
                if (ACC_EN && bus.wr_acc) begin
                    acc_left = 2;
                    acc_bank = int'(bus.wr_bank);
                    acc_key  = int'(bus.wr_bank) * (1 << AB) + int'(bus.wr_addr);
                    acc_d    = bus.wr_data;
                end else begin
                    mdl[int'(bus.wr_bank) * (1 << AB) + int'(bus.wr_addr)] = bus.wr_data;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic b, input logic [AB-1:0] a, input logic [DW-1:0] d, input logic acc);
        bus.wr_valid = 1'b1;
        bus.wr_bank  = b;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_acc   = acc;
    endtask

    task automatic set_rd(input logic b, input logic [AB-1:0] a);
        bus.rd_valid_in = 1'b1;
        bus.rd_bank     = b;
        bus.rd_addr     = a;
    endtask

    task automatic wr(input logic b, input logic [AB-1:0] a, input logic [DW-1:0] d, input logic acc);
        set_wr(b, a, d, acc);
        cyc();
        bus.wr_valid = 1'b0;
        bus.wr_acc   = 1'b0;
    endtask

    task automatic rd_expect(input logic b, input logic [AB-1:0] a, input int exp, input string name);
        bit ok;
        ok = 1'b0;
        set_rd(b, a);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rd_ready) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (!ok) begin
            chk({name, "_timeout"}, 0, 1);
            cyc();
            bus.rd_valid_in = 1'b0;
        end else begin
            cyc();
            bus.rd_valid_in = 1'b0;
            @(negedge clk);
            chk({name, "_valid"}, bus.rd_valid, 1);
            chk(name, bus.rd_data, exp);
            cyc();
        end
    endtask

    initial begin
        bus.wr_valid = 1'b0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_acc = 1'b0;
        bus.rd_valid_in = 1'b0; bus.rd_bank = '0; bus.rd_addr = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_rd_valid", bus.rd_valid, 0);
        repeat (2) cyc();
        rst = 1'b0;

        wr(1'b0, 11'd5, 8'h12, 1'b0);
        rd_expect(1'b0, 11'd5, 8'h12, "wr_then_rd");

        set_wr(1'b1, 11'd3, 8'h07, 1'b0);
        set_rd(1'b0, 11'd5);
        @(negedge clk);
        chk("diff_bank_rd_ready", bus.rd_ready, 1);
        chk("diff_bank_wr_ready", bus.wr_ready, 1);
        cyc();
        bus.wr_valid = 1'b0; bus.rd_valid_in = 1'b0;
        @(negedge clk);
        chk("diff_bank_rd_data", bus.rd_data, 8'h12);
        cyc();

        set_wr(1'b0, 11'd9, 8'h5A, 1'b0);
        set_rd(1'b0, 11'd9);
        @(negedge clk);
        chk("same_bank_rd_ready", bus.rd_ready, 0);
        cyc();
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("held_rd_ready", bus.rd_ready, 1);
        cyc();
        bus.rd_valid_in = 1'b0;
        @(negedge clk);
        chk("held_rd_data", bus.rd_data, 8'h5A);
        cyc();

        wr(1'b1, 11'd2047, 8'h80, 1'b0);
        wr(1'b0, 11'd0, 8'h01, 1'b0);
        set_rd(1'b1, 11'd2047); cyc();
        set_rd(1'b1, 11'd3);    cyc();
        set_rd(1'b0, 11'd9);    cyc();
        bus.rd_valid_in = 1'b0;
        cyc();
        rd_expect(1'b1, 11'd3, 8'h07, "bank1_addr3");
        rd_expect(1'b1, 11'd2047, 8'h80, "top_addr");

`ifdef OFM_ACC_EN
        wr(1'b0, 11'd0, 8'h70, 1'b0);
        wr(1'b0, 11'd0, 8'h20, 1'b1);
        set_rd(1'b1, 11'd3);
        @(negedge clk);
        chk("acc_rd_busy", bus.busy, 1);
        chk("acc_rd_wr_ready", bus.wr_ready, 0);
        chk("acc_other_bank_rd_ready", bus.rd_ready, 1);
        cyc();
        set_rd(1'b0, 11'd5);
        @(negedge clk);
        chk("acc_wr_busy", bus.busy, 1);
        chk("acc_wr_wr_ready", bus.wr_ready, 0);
        chk("acc_same_bank_rd_ready", bus.rd_ready, 0);
        chk("acc_other_bank_rd_data", bus.rd_data, 8'h07);
        cyc();
        @(negedge clk);
        chk("acc_done_busy", bus.busy, 0);
        chk("acc_done_rd_ready", bus.rd_ready, 1);
        cyc();
        bus.rd_valid_in = 1'b0;
        @(negedge clk);
        chk("acc_stalled_rd_data", bus.rd_data, 8'h12);
        cyc();
        rd_expect(1'b0, 11'd0, 8'h7F, "acc_sat_pos");

        wr(1'b0, 11'd1, 8'h05, 1'b0);
        wr(1'b0, 11'd1, 8'hFD, 1'b1);
        rd_expect(1'b0, 11'd1, 8'h02, "acc_signed");

        wr(1'b0, 11'd2, 8'h90, 1'b0);
        wr(1'b0, 11'd2, 8'hC0, 1'b1);
        rd_expect(1'b0, 11'd2, 8'h80, "acc_sat_neg");

        wr(1'b1, 11'd4, 8'h33, 1'b0);
        wr(1'b1, 11'd4, 8'h01, 1'b1);
        cyc();
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_wr_ready", bus.wr_ready, 1);
        cyc();
        rst = 1'b0;
        rd_expect(1'b1, 11'd4, 8'h33, "abort_keeps_old");
`else
        wr(1'b0, 11'd2, 8'h10, 1'b0);
        set_wr(1'b0, 11'd2, 8'h03, 1'b1);
        @(negedge clk);
        chk("noacc_busy_req", bus.busy, 0);
        cyc();
        bus.wr_valid = 1'b0; bus.wr_acc = 1'b0;
        @(negedge clk);
        chk("noacc_busy_after", bus.busy, 0);
        chk("noacc_wr_ready", bus.wr_ready, 1);
        cyc();
        rd_expect(1'b0, 11'd2, 8'h03, "noacc_overwrite");
`endif

        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
